vio_cmd_issuer: RTL and testbench
=================================

Name: vio_cmd_issuer

Overview:
- Consumes the 64-bit VIO SYNC_OUT word from the debug core and turns operator-written fields into one command transaction toward the NAND controller command port.
- Tracks each command through a valid/ready handshake, then waits for a done pulse or a timeout.
- Returns live status and counters on a 64-bit word that feeds VIO SYNC_IN, plus one 16-bit word for an ILA trigger input.

Parameters:
- TIMEOUT_CYCLES, 65535, cycles allowed in WAIT_DONE before a timeout is declared; must be at least 1.
- ADDR_STRIDE, 1, address increment per repeated command (used only with the optional feature).

Ports:
- v_clk0  in  1  sole clock; the VIO is synchronous to it.
- v_rst0  in  1  reset, synchronous, active-high.
- vio_out  in  64  VIO SYNC_OUT. Field layout:
  - [63] request toggle
  - [62:60] opcode
  - [59:52] repeat count minus 1
  - [51:48] chip select
  - [47:32] tag
  - [31:0] address
- vio_in  out  64  VIO SYNC_IN. Field layout:
  - [63:48] issued count
  - [47:32] done count
  - [31:16] timeout count
  - [15:8] last cmd_status
  - [7] overflow sticky
  - [6] stray-done sticky
  - [5:3] reserved 0
  - [2:0] state
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  controller accepts the command.
- cmd_op  out  3  opcode.
- cmd_chip  out  4  chip select.
- cmd_tag  out  16  tag.
- cmd_addr  out  32  address.
- cmd_done  in  1  one-cycle completion pulse.
- cmd_status  in  8  status qualified by cmd_done.
- dbg_word  out  16  ILA word. Field layout:
  - [15:13] state
  - [12] cmd_valid
  - [11] cmd_ready
  - [10] cmd_done
  - [9:0] timeout counter [9:0]

Behaviour:
- All registers are cleared on the v_rst0 edge. Reset values: every output 0; state ARM.
- Reset mid-operation: cmd_valid falls on the reset edge; an outstanding command is abandoned and is not counted.
- Register stage: vio_out is registered once into vio_q. Edge detect: req = vio_q[63] ^ tog_seen.
- States:
  - ARM(0): load tog_seen <= vio_q[63]; go to IDLE. A toggle already set at reset release never fires.
  - IDLE(1): when req, capture op, chip, tag, addr and rpt from vio_q; set tog_seen; go to ISSUE. cmd_valid rises 2 cycles after vio_out[63] changes.
  - ISSUE(2): hold cmd_valid and all fields stable until cmd_ready. Handshake cycle: issued count +1, timeout counter cleared, go to WAIT_DONE, cmd_valid low the next cycle.
  - WAIT_DONE(3): timeout counter increments each cycle.
    - On cmd_done: latch cmd_status; done count +1; go to NEXT.
    - Else if counter == TIMEOUT_CYCLES-1: timeout count +1; last status = 0xFF; go to NEXT.
    - If cmd_done arrives on the timeout cycle, done wins.
  - NEXT(4): remaining repeats > 0 → decrement, addr += ADDR_STRIDE, go to ISSUE; otherwise go to IDLE.
- Request toggles while not in IDLE/ARM: tog_seen is updated and overflow sticky is set; the request is dropped (no queue).
- cmd_done outside WAIT_DONE: ignored; stray-done sticky is set.
- Stickies clear only on reset.
- The three 16-bit counters saturate at 0xFFFF.
- cmd_addr addition wraps modulo 2^32.
- vio_in and dbg_word are registered: one-cycle lag from internal state.

Optional Feature:
- Macro: VIO_CMD_REPEAT_EN.
- Defined: the rpt field [59:52] is honoured; rpt+1 commands are issued back-to-back through NEXT, address stepping by ADDR_STRIDE, all with the same tag and opcode.
- Undefined: the field is ignored, rpt is forced to 0, ADDR_STRIDE is unused, and NEXT always returns to IDLE.

Decomposition:
- Package vio_cmd_pkg holds:
  - state encoding localparams (ARM..NEXT)
  - vio_out/vio_in bit-offset constants
  - opcode constants (READ, WRITE, ERASE, RESET_CHIP, READ_ID)
- Natural sub-module: sat_cnt16, a 16-bit saturating incrementer with sync reset, instantiated three times.

Test Plan:
- Reset with vio_out[63]=1 held → after release there is no cmd_valid and state goes ARM→IDLE; vio_in == 0 except state == 1.
- Toggle [63] 0→1 with op=1, addr=0x1000, tag=0xBEEF → cmd_valid rises 2 cycles later with matching fields. Hold cmd_ready low for 5 cycles, fields stay stable. After cmd_ready, assert cmd_done with status 0x00 → issued=1, done=1, last status 0x00.
- TIMEOUT_CYCLES=8, no cmd_done → timeout after 8 WAIT_DONE cycles; timeout count=1; last status 0xFF; return to IDLE.
- Toggle twice while in WAIT_DONE → overflow sticky set, no extra command issued. A cmd_done pulse in IDLE sets stray-done sticky.
- VIO_CMD_REPEAT_EN defined, rpt=3, addr=0xFFFFFFFE, ADDR_STRIDE=1 → 4 commands at addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; issued=4. Undefined → exactly 1 command.
- Assert v_rst0 during ISSUE with cmd_valid high → cmd_valid is 0 on the next edge and counters are 0. Preload issued at 0xFFFF → stays 0xFFFF after a further command.

Source files
------------

// File: rtl/vio_cmd_pkg.sv
// Shared definitions for the VIO command issuer.
// Holds the FSM state encoding, the bit offsets of the VIO SYNC_OUT / SYNC_IN
// words and the NAND controller opcode values.
// Contents: ST_* state codes, state_e enum, VO_* and VI_* field offsets, OP_* opcodes.
package vio_cmd_pkg;

    // FSM state codes, also reported on vio_in[2:0] and dbg_word[15:13].
    localparam logic [2:0] ST_ARM       = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_NEXT      = 3'd4;

    typedef enum logic [2:0] {
        S_ARM       = ST_ARM,
        S_IDLE      = ST_IDLE,
        S_ISSUE     = ST_ISSUE,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_NEXT      = ST_NEXT
    } state_e;

    // VIO SYNC_OUT field offsets.
    localparam int VO_TOG      = 63;
    localparam int VO_OP_LSB   = 60;
    localparam int VO_RPT_LSB  = 52;
    localparam int VO_CHIP_LSB = 48;
    localparam int VO_TAG_LSB  = 32;
    localparam int VO_ADDR_LSB = 0;

    // VIO SYNC_IN field offsets.
    localparam int VI_ISSUED_LSB = 48;
    localparam int VI_DONE_LSB   = 32;
    localparam int VI_TMO_LSB    = 16;
    localparam int VI_STATUS_LSB = 8;
    localparam int VI_OVF        = 7;
    localparam int VI_STRAY      = 6;
    localparam int VI_STATE_LSB  = 0;

    // NAND controller opcodes.
    localparam logic [2:0] OP_READ       = 3'd0;
    localparam logic [2:0] OP_WRITE      = 3'd1;
    localparam logic [2:0] OP_ERASE      = 3'd2;
    localparam logic [2:0] OP_RESET_CHIP = 3'd3;
    localparam logic [2:0] OP_READ_ID    = 3'd4;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that holds at 0xFFFF instead of wrapping.
// Ports: clk (clock), rst (sync active-high clear), inc (count enable),
//        count (current value, registered).
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    // Saturating increment with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/vio_cmd_issuer.sv
// Turns operator-written VIO SYNC_OUT fields into command transactions toward
// the NAND controller command port and reports status/counters back.
// A change of vio_out[63] requests one command (or rpt+1 commands when the
// VIO_CMD_REPEAT_EN macro is defined). Each command does a valid/ready
// handshake and then waits for cmd_done or a timeout.
// Ports:
//   v_clk0, v_rst0         clock, synchronous active-high reset
//   vio_out / vio_in       VIO SYNC_OUT request word / SYNC_IN status word
//   cmd_valid, cmd_ready   command handshake
//   cmd_op/chip/tag/addr   command fields, stable while cmd_valid is high
//   cmd_done, cmd_status   completion pulse and its status byte
//   dbg_word               ILA trigger word
// Config macro: VIO_CMD_REPEAT_EN (honour the repeat-count field).
module vio_cmd_issuer
    import vio_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned ADDR_STRIDE    = 1
) (
    input  logic        v_clk0,
    input  logic        v_rst0,
    input  logic [63:0] vio_out,
    output logic [63:0] vio_in,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [3:0]  cmd_chip,
    output logic [15:0] cmd_tag,
    output logic [31:0] cmd_addr,
    input  logic        cmd_done,
    input  logic [7:0]  cmd_status,
    output logic [15:0] dbg_word
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_r, state_n;
    logic [63:0] vio_q_r;
    logic        tog_seen_r, tog_seen_n;
    logic [2:0]  op_r;
    logic [3:0]  chip_r;
    logic [15:0] tag_r;
    logic [31:0] addr_r;
    logic [7:0]  rpt_r;
    logic        cmd_valid_r;
    logic [15:0] tmo_cnt_r;
    logic [7:0]  status_r;
    logic        ovf_r;
    logic        stray_r;
    logic [63:0] vio_in_r;
    logic [15:0] dbg_r;

    logic        req_s;
    logic        load_s;
    logic        step_s;
    logic        hs_s;
    logic        done_s;
    logic        tmo_s;
    logic        ovf_set_s;
    logic        stray_set_s;
    logic [7:0]  rpt_field_s;
    logic [15:0] issued_s;
    logic [15:0] done_cnt_s;
    logic [15:0] tmo_evt_s;

`ifdef VIO_CMD_REPEAT_EN
    assign rpt_field_s = vio_q_r[VO_RPT_LSB +: 8];
`else
    logic unused_rpt_s;
    assign rpt_field_s  = 8'd0;
    assign unused_rpt_s = ^vio_q_r[VO_RPT_LSB +: 8];
`endif

    assign req_s       = vio_q_r[VO_TOG] ^ tog_seen_r;
    assign stray_set_s = cmd_done && (state_r != S_WAIT_DONE);

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        state_n    = state_r;
        tog_seen_n = tog_seen_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        hs_s       = 1'b0;
        done_s     = 1'b0;
        tmo_s      = 1'b0;
        ovf_set_s  = 1'b0;
        case (state_r)
            S_ARM: begin
                // Sample the toggle that vio_q captures on this same edge so a
                // toggle already set when reset releases is never seen as a request.
                tog_seen_n = vio_out[VO_TOG];
                state_n    = S_IDLE;
            end
            S_IDLE: begin
                if (req_s) begin
                    tog_seen_n = vio_q_r[VO_TOG];
                    load_s     = 1'b1;
                    state_n    = S_ISSUE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    hs_s    = 1'b1;
                    state_n = S_WAIT_DONE;
                end else begin
                    state_n = S_ISSUE;
                end
            end
            S_WAIT_DONE: begin
                // A done pulse on the final timeout cycle still counts as done.
                if (cmd_done) begin
                    done_s  = 1'b1;
                    state_n = S_NEXT;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_s   = 1'b1;
                    state_n = S_NEXT;
                end else begin
                    state_n = S_WAIT_DONE;
                end
            end
            S_NEXT: begin
                if (rpt_r != 8'd0) begin
                    step_s  = 1'b1;
                    state_n = S_ISSUE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_ARM;
            end
        endcase
        // Requests arriving while busy are consumed and dropped, not queued.
        if (req_s && (state_r != S_IDLE) && (state_r != S_ARM)) begin
            tog_seen_n = vio_q_r[VO_TOG];
            ovf_set_s  = 1'b1;
        end else begin
            ovf_set_s = 1'b0;
        end
    end

    // State, captured command fields, timeout counter, stickies and output words.
    always_ff @(posedge v_clk0) begin
        if (v_rst0) begin
            state_r     <= S_ARM;
            vio_q_r     <= 64'd0;
            tog_seen_r  <= 1'b0;
            op_r        <= 3'd0;
            chip_r      <= 4'd0;
            tag_r       <= 16'd0;
            addr_r      <= 32'd0;
            rpt_r       <= 8'd0;
            cmd_valid_r <= 1'b0;
            tmo_cnt_r   <= 16'd0;
            status_r    <= 8'd0;
            ovf_r       <= 1'b0;
            stray_r     <= 1'b0;
            vio_in_r    <= 64'd0;
            dbg_r       <= 16'd0;
        end else begin
            state_r     <= state_n;
            vio_q_r     <= vio_out;
            tog_seen_r  <= tog_seen_n;
            cmd_valid_r <= (state_n == S_ISSUE);
            if (load_s) begin
                op_r   <= vio_q_r[VO_OP_LSB +: 3];
                chip_r <= vio_q_r[VO_CHIP_LSB +: 4];
                tag_r  <= vio_q_r[VO_TAG_LSB +: 16];
                addr_r <= vio_q_r[VO_ADDR_LSB +: 32];
                rpt_r  <= rpt_field_s;
            end else if (step_s) begin
                rpt_r  <= rpt_r - 8'd1;
                addr_r <= addr_r + 32'(ADDR_STRIDE);
            end else begin
                rpt_r  <= rpt_r;
                addr_r <= addr_r;
            end
            if (hs_s) begin
                tmo_cnt_r <= 16'd0;
            end else if (state_r == S_WAIT_DONE) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
            if (done_s) begin
                status_r <= cmd_status;
            end else if (tmo_s) begin
                status_r <= 8'hFF;
            end else begin
                status_r <= status_r;
            end
            ovf_r    <= ovf_r | ovf_set_s;
            stray_r  <= stray_r | stray_set_s;
            vio_in_r <= {issued_s, done_cnt_s, tmo_evt_s, status_r,
                         ovf_r, stray_r, 3'b000, state_r};
            dbg_r    <= {state_r, cmd_valid_r, cmd_ready, cmd_done, tmo_cnt_r[9:0]};
        end
    end

    sat_cnt16 u_issued (.clk(v_clk0), .rst(v_rst0), .inc(hs_s),   .count(issued_s));
    sat_cnt16 u_done   (.clk(v_clk0), .rst(v_rst0), .inc(done_s), .count(done_cnt_s));
    sat_cnt16 u_tmo    (.clk(v_clk0), .rst(v_rst0), .inc(tmo_s),  .count(tmo_evt_s));

    assign cmd_valid = cmd_valid_r;
    assign cmd_op    = op_r;
    assign cmd_chip  = chip_r;
    assign cmd_tag   = tag_r;
    assign cmd_addr  = addr_r;
    assign vio_in    = vio_in_r;
    assign dbg_word  = dbg_r;

endmodule

// File: tb/tb_vio_cmd_issuer.sv
// Self-checking bench for vio_cmd_issuer: table of directed requests, randomized
// requests scored against a transaction-level model, and hand-written sequences
// for reset, overflow, stray-done and counter saturation.
module tb_vio_cmd_issuer;
    import vio_cmd_pkg::*;

    localparam int          TMO    = 8;
    localparam int unsigned STRIDE = 1;
`ifdef VIO_CMD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        v_rst0;
    logic [63:0] vio_out;
    logic [63:0] vio_in;
    logic        cmd_valid, cmd_ready, cmd_done;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_chip;
    logic [15:0] cmd_tag;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_status;
    logic [15:0] dbg_word;
    logic        sat_rst, sat_inc;
    logic [15:0] sat_count;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [15:0]  exp_issued, exp_done, exp_tmo;
    logic [7:0]   exp_status;
    logic         exp_ovf, exp_stray;
    logic         tog;
    logic [54:0]  exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  chip;
        logic [15:0] tag;
        logic [31:0] addr;
        logic [7:0]  rpt;
        int          ready_dly;
        int          done_dly;
        logic [7:0]  status;
        logic [7:0]  exp_last;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    vio_cmd_issuer #(.TIMEOUT_CYCLES(TMO), .ADDR_STRIDE(STRIDE)) dut (
        .v_clk0(clk), .v_rst0(v_rst0), .vio_out(vio_out), .vio_in(vio_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_chip(cmd_chip), .cmd_tag(cmd_tag), .cmd_addr(cmd_addr),
        .cmd_done(cmd_done), .cmd_status(cmd_status), .dbg_word(dbg_word)
    );

    sat_cnt16 u_sat (.clk(clk), .rst(sat_rst), .inc(sat_inc), .count(sat_count));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [63:0] exp_vio();
        return {exp_issued, exp_done, exp_tmo, exp_status, exp_ovf, exp_stray, 3'b000, 3'd1};
    endfunction

    task automatic model_reset();
        exp_issued = 16'd0; exp_done = 16'd0; exp_tmo = 16'd0;
        exp_status = 8'd0;  exp_ovf = 1'b0;   exp_stray = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_req(input logic [2:0] op, input logic [3:0] chip,
                            input logic [15:0] tag, input logic [31:0] addr,
                            input logic [7:0] rpt);
        tog = ~tog;
        vio_out = {tog, op, rpt, chip, tag, addr};
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!cmd_valid && n < 20) begin
            tick();
            n++;
        end
        check("valid_wait", {63'd0, cmd_valid}, 64'd1);
    endtask

    // One request: model predicts the command list, bench plays controller.
    task automatic do_request(input logic [2:0] op, input logic [3:0] chip,
                              input logic [15:0] tag, input logic [31:0] addr,
                              input logic [7:0] rpt, input int ready_dly,
                              input int done_dly, input logic [7:0] status);
        int n_cmds;
        logic [54:0] expc;
        n_cmds = REPEAT_ON ? (int'(rpt) + 1) : 1;
        for (int k = 0; k < n_cmds; k++)
            exp_q.push_back({op, chip, tag, addr + STRIDE * 32'(k)});
        send_req(op, chip, tag, addr, rpt);
        tick();
        check("valid_lat1", {63'd0, cmd_valid}, 64'd0);
        tick();
        check("valid_lat2", {63'd0, cmd_valid}, 64'd1);
        for (int k = 0; k < n_cmds; k++) begin
            if (k != 0) wait_valid();
            expc = (exp_q.size() != 0) ? exp_q.pop_front() : 55'd0;
            check("cmd_fields", {9'd0, cmd_op, cmd_chip, cmd_tag, cmd_addr}, {9'd0, expc});
            for (int d = 0; d < ready_dly; d++) begin
                tick();
                check("hold_stable", {8'd0, cmd_valid, cmd_op, cmd_chip, cmd_tag, cmd_addr},
                      {8'd0, 1'b1, expc});
                check("dbg_issue", {58'd0, dbg_word[15:10]}, {58'd0, ST_ISSUE, 3'b100});
            end
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            check("valid_drop", {63'd0, cmd_valid}, 64'd0);
            exp_issued = sat16(exp_issued);
            if (done_dly < TMO) begin
                repeat (done_dly) tick();
                cmd_done = 1'b1;
                cmd_status = status;
                tick();
                cmd_done = 1'b0;
                exp_done = sat16(exp_done);
                exp_status = status;
            end else begin
                repeat (TMO) tick();
                exp_tmo = sat16(exp_tmo);
                exp_status = 8'hFF;
            end
        end
        tick();
        tick();
        check("vio_in", vio_in, exp_vio());
        check("idle_no_valid", {63'd0, cmd_valid}, 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{OP_WRITE,   4'd2,  16'hBEEF, 32'h0000_1000, 8'd0, 5, 0,  8'h00, 8'h00};
        vecs[1] = '{OP_READ,    4'd0,  16'h1234, 32'h0000_2000, 8'd0, 0, 20, 8'h77, 8'hFF};
        vecs[2] = '{OP_ERASE,   4'd7,  16'h0042, 32'h0000_3000, 8'd0, 1, 7,  8'h5A, 8'h5A};
        vecs[3] = '{OP_RESET_CHIP, 4'd3, 16'h0001, 32'h8000_0000, 8'd0, 2, 6, 8'h01, 8'h01};
        vecs[4] = '{OP_WRITE,   4'd1,  16'hA5A5, 32'hFFFF_FFFE, 8'd3, 1, 2,  8'h33, 8'h33};
        vecs[5] = '{OP_READ_ID, 4'd15, 16'hFFFF, 32'hFFFF_FFFF, 8'd0, 0, 0,  8'h80, 8'h80};

        v_rst0 = 1'b1; cmd_ready = 1'b0; cmd_done = 1'b0; cmd_status = 8'd0;
        sat_rst = 1'b1; sat_inc = 1'b0;
        tog = 1'b1;
        vio_out = {1'b1, 63'd0};
        model_reset();
        repeat (3) tick();
        check("rst_valid", {63'd0, cmd_valid}, 64'd0);
        check("rst_vio_in", vio_in, 64'd0);
        check("rst_dbg", {48'd0, dbg_word}, 64'd0);
        v_rst0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("armed_no_fire", {63'd0, cmd_valid}, 64'd0);
        end
        check("armed_vio_in", vio_in, exp_vio());

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            do_request(vecs[i].op, vecs[i].chip, vecs[i].tag, vecs[i].addr, vecs[i].rpt,
                       vecs[i].ready_dly, vecs[i].done_dly, vecs[i].status);
            check("row_status", {56'd0, vio_in[15:8]}, {56'd0, vecs[i].exp_last});
        end

        // Randomized requests against the model.
        for (int i = 0; i < 30; i++) begin
            do_request(3'($urandom_range(0, 4)), 4'($urandom), 16'($urandom), $urandom,
                       8'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 10)), 8'($urandom));
        end

        // Two toggles while waiting for done: flagged, neither issued.
        exp_q.push_back({OP_WRITE, 4'd1, 16'h0F0F, 32'h40});
        send_req(OP_WRITE, 4'd1, 16'h0F0F, 32'h40, 8'd0);
        tick(); tick();
        check("ovf_valid", {63'd0, cmd_valid}, 64'd1);
        check("ovf_fields", {9'd0, cmd_op, cmd_chip, cmd_tag, cmd_addr}, {9'd0, exp_q.pop_front()});
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        exp_issued = sat16(exp_issued);
        tog = ~tog; vio_out[63] = tog; tick(); tick();
        tog = ~tog; vio_out[63] = tog; tick(); tick();
        cmd_done = 1'b1; cmd_status = 8'h11; tick(); cmd_done = 1'b0;
        exp_done = sat16(exp_done); exp_status = 8'h11; exp_ovf = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ovf_no_extra", {63'd0, cmd_valid}, 64'd0);
        end
        check("ovf_vio_in", vio_in, exp_vio());

        // Done pulse while idle.
        cmd_done = 1'b1; tick(); cmd_done = 1'b0;
        exp_stray = 1'b1;
        tick(); tick();
        check("stray_vio_in", vio_in, exp_vio());

        // Reset while a command is being offered.
        send_req(OP_ERASE, 4'd5, 16'h7777, 32'h1234_5678, 8'd0);
        tick(); tick();
        check("pre_rst_valid", {63'd0, cmd_valid}, 64'd1);
        v_rst0 = 1'b1;
        tick();
        check("midrst_valid", {63'd0, cmd_valid}, 64'd0);
        check("midrst_vio_in", vio_in, 64'd0);
        tick();
        v_rst0 = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("postrst_no_fire", {63'd0, cmd_valid}, 64'd0);
        end
        check("postrst_vio_in", vio_in, exp_vio());
        do_request(OP_READ, 4'd9, 16'hCAFE, 32'h0000_0100, 8'd0, 1, 3, 8'h0C);

        // Counter saturation.
        sat_rst = 1'b0;
        tick();
        check("sat_zero", {48'd0, sat_count}, 64'd0);
        sat_inc = 1'b1;
        repeat (65534) tick();
        check("sat_fffe", {48'd0, sat_count}, 64'h0000_0000_0000_FFFE);
        tick();
        check("sat_ffff", {48'd0, sat_count}, 64'h0000_0000_0000_FFFF);
        repeat (3) tick();
        check("sat_hold", {48'd0, sat_count}, 64'h0000_0000_0000_FFFF);
        sat_inc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
